// File: rtl/code_pack.sv
// rtl/code_pack.sv - shared opcode constants and fetch-stage types for the 9-bit CPU
package code_pack;

  localparam int INSTR_W = 9;

  localparam logic [4:0] FUNC = 5'b11111;
  localparam logic [3:0] DONE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_done(input logic [INSTR_W-1:0] i);
    return i == {FUNC, DONE};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-to-decode instruction handshake
interface instr_fetch_if #(
  parameter int PC_W = 10
);
  import code_pack::*;

  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ready;

  modport master (output instr, output instr_pc, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_pc, input instr_valid, output instr_ready);

endinterface

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry skid buffer in front of the registered decode output
module fetch_skid
  import code_pack::*;
#(
  parameter int PC_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_data,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_data,
  output logic [PC_W-1:0]    out_pc
);

  logic               skid_valid;
  logic [INSTR_W-1:0] skid_data;
  logic [PC_W-1:0]    skid_pc;

  assign in_ready = !skid_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_pc     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_ready || !out_valid) begin
      // Skid drains first so ordering is preserved; it blocks new input while full.
      if (skid_valid) begin
        out_data   <= skid_data;
        out_pc     <= skid_pc;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_data <= in_data;
          out_pc   <= in_pc;
        end
      end
    end else if (in_valid && in_ready) begin
      skid_data  <= in_data;
      skid_pc    <= in_pc;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, sync ROM addressing, redirect and halt control
module instr_fetch
  import code_pack::*;
#(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  instr_fetch_if.master      dec,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_HALT = 2'(HALT);

  logic [1:0]      state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] rd_pc;
  logic            rd_valid;
  logic            skid_in_ready;

  logic       running, do_start, do_redirect, accept, do_halt, flush, issue;
  logic [1:0] occ;

  assign running     = (state == ST_RUN);
  assign do_start    = start && !running;
  assign do_redirect = running && redirect;
  assign accept      = running && dec.instr_valid && dec.instr_ready && !redirect;
  assign do_halt     = accept && is_done(dec.instr);
  assign flush       = do_start || do_redirect || do_halt;

  // Words held after this edge (output + skid + in-flight, minus the accepted one);
  // a new ROM read is issued only if its word is guaranteed a slot next cycle.
  assign occ   = {1'b0, dec.instr_valid} + {1'b0, !skid_in_ready} + {1'b0, rd_valid}
               - {1'b0, accept};
  assign issue = running && !flush && (occ <= 2'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= START_PC;
      rd_pc       <= '0;
      rd_valid    <= 1'b0;
      fetch_count <= '0;
    end else if (do_start) begin
      state       <= ST_RUN;
      pc          <= START_PC;
      rd_valid    <= 1'b0;
      fetch_count <= '0;
    end else if (running) begin
      if (do_redirect) begin
        pc       <= redirect_pc;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= issue;
        if (issue) begin
          rd_pc <= pc;
          pc    <= pc + 1'b1;
        end
        if (accept) fetch_count <= fetch_count + 16'd1;
        if (do_halt) state <= ST_HALT;
      end
    end
  end

  fetch_skid #(.PC_W(PC_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (rd_valid),
    .in_ready  (skid_in_ready),
    .in_data   (imem_data),
    .in_pc     (rd_pc),
    .out_valid (dec.instr_valid),
    .out_ready (dec.instr_ready),
    .out_data  (dec.instr),
    .out_pc    (dec.instr_pc)
  );

  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);

endmodule
